dct_npt: RTL and testbench
==========================

DCT_NPT -- requirements
Module: dct_npt

Interface
REQ-001 Parameter N, default 4: transform length; legal values 4 and 8 only, any other value a compile-time error.
REQ-002 Parameter IN_W, default 8: input sample width.
REQ-003 Parameter OUT_W, default 10: output coefficient width, signed two's complement.
REQ-004 Parameter SHIFT, default 7: right-shift applied to each accumulated sum; legal range 0..16.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  in_data carries a sample this cycle.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 in_data  input  IN_W  sample; unsigned in forward mode.
REQ-010 inv_mode  input  1  present only with DCT_INV_EN; 1 selects inverse transform.
REQ-011 out_valid  output  1  out_data carries a coefficient this cycle.
REQ-012 out_data  output  OUT_W  result sample, signed.

Function
REQ-013 Sample accepted on a rising edge with in_valid=1 and in_ready=1; samples offered while in_ready=0 are ignored.
REQ-014 States: LOAD (collecting samples), CALC (multiply-accumulate), OUT (emitting results).
REQ-015 LOAD: in_ready=1; accepted samples stored at index 0..N-1 in arrival order; on the Nth accepted sample, go to CALC.
REQ-016 A block's N samples arrive on consecutive cycles; in_valid=0 in LOAD after at least one sample discards the partial block, resetting the sample count to 0 with no output.
REQ-017 CALC: exactly N*N cycles, one multiply-accumulate per cycle, in_ready=0; y[k] = sum over n of C[k][n]*x[n] for k=0..N-1.
REQ-018 C for N=4: rows {64,64,64,64}, {83,36,-36,-83}, {64,-64,-64,64}, {36,-83,83,-36}; for N=8: the H.265 8-point integer core transform matrix (row 0 all 64, row 1 {89,75,50,18,-18,-50,-75,-89}).
REQ-019 Accumulator width IN_W+2+7+log2(N) bits, signed; no internal overflow for any legal input.
REQ-020 Result = (sum + 2^(SHIFT-1)) arithmetic-shifted right by SHIFT (no rounding term when SHIFT=0), then saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-021 OUT: out_valid=1 for exactly N consecutive cycles, y[0] first through y[N-1]; in_ready=0; then return to LOAD.
REQ-022 Latency: Nth sample accepted at edge t gives first out_valid in the cycle after edge t+N*N; in_ready=1 in the cycle after the last output.
REQ-023 out_data=0 whenever out_valid=0.

Reset
REQ-024 rst=1 immediately forces state LOAD, sample count 0, accumulators 0, in_ready=1, out_valid=0, out_data=0.
REQ-025 rst asserted during CALC or OUT abandons the block; no remaining outputs appear after release.
REQ-026 First sample accepted on the first rising edge with rst=0 and in_valid=1.

Configuration
REQ-027 Macro DCT_INV_EN defined: inv_mode port exists, sampled with the first sample of each block and held for that block; inv_mode=1 interprets in_data as signed and computes x'[n] = sum over k of C[k][n]*y[k] (transpose), same rounding, saturation and timing.
REQ-028 DCT_INV_EN undefined: no inv_mode port; forward transform only; no inverse logic synthesised.

Verification
REQ-029 N=4, defaults, samples 100,100,100,100 -> outputs 200,0,0,0; first out_valid 16 cycles after the 4th sample.
REQ-030 N=4, samples 255,0,0,0 -> outputs 128,165,128,72.
REQ-031 N=4, SHIFT=6, samples 255,255,255,255 -> outputs 511 (saturated),0,0,0.
REQ-032 Two samples, in_valid low one cycle, then 100 x4 -> no output for the partial block; outputs 200,0,0,0.
REQ-033 rst pulsed during CALC -> out_valid stays 0, in_ready=1 immediately; next block 255,0,0,0 yields 128,165,128,72.
REQ-034 DCT_INV_EN, N=4, inv_mode=1, inputs 100,0,0,0 -> outputs 50,50,50,50.

Source files
------------

// File: rtl/dct_npt.sv
// N-point (4 or 8) integer DCT using the H.265 core matrix: one MAC per cycle, rounded,
// shifted and saturated outputs. Define DCT_INV_EN to add the inv_mode port and the transposed (inverse) transform.
module dct_npt #(
  parameter int N     = 4,
  parameter int IN_W  = 8,
  parameter int OUT_W = 10,
  parameter int SHIFT = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
`ifdef DCT_INV_EN
  input  logic             inv_mode,
`endif
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       state_dbg
);

  if (!(N == 4 || N == 8)) begin : g_bad_n
    $error("dct_npt: N must be 4 or 8");
  end
  if (SHIFT < 0 || SHIFT > 16) begin : g_bad_shift
    $error("dct_npt: SHIFT must be in 0..16");
  end

  localparam int LOGN = (N == 8) ? 3 : 2;
  localparam int AW   = IN_W + 2 + 7 + LOGN;
  localparam int RW   = ((AW > 17) ? AW : 17) + 2;
  localparam logic [LOGN-1:0] ONE  = LOGN'(1);
  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);
  localparam longint SAT_MAX = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
  localparam longint SAT_MIN = -(64'sd1 <<< (OUT_W - 1));
  localparam logic signed [RW-1:0] RND =
    RW'((SHIFT == 0) ? 64'sd0 : (64'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)));

  // N=4 uses the even rows (first four columns) of the 8-point matrix.
  localparam logic signed [7:0] C8 [8][8] = '{
    '{8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64},
    '{8'sd89,  8'sd75,  8'sd50,  8'sd18, -8'sd18, -8'sd50, -8'sd75, -8'sd89},
    '{8'sd83,  8'sd36, -8'sd36, -8'sd83, -8'sd83, -8'sd36,  8'sd36,  8'sd83},
    '{8'sd75, -8'sd18, -8'sd89, -8'sd50,  8'sd50,  8'sd89,  8'sd18, -8'sd75},
    '{8'sd64, -8'sd64, -8'sd64,  8'sd64,  8'sd64, -8'sd64, -8'sd64,  8'sd64},
    '{8'sd50, -8'sd89,  8'sd18,  8'sd75, -8'sd75, -8'sd18,  8'sd89, -8'sd50},
    '{8'sd36, -8'sd83,  8'sd83, -8'sd36, -8'sd36,  8'sd83, -8'sd83,  8'sd36},
    '{8'sd18, -8'sd50,  8'sd75, -8'sd89,  8'sd89, -8'sd75,  8'sd50, -8'sd18}
  };

  typedef enum logic [1:0] {S_LOAD = 2'd0, S_CALC = 2'd1, S_OUT = 2'd2} state_t;

  state_t                  state;
  logic [LOGN-1:0]         s_cnt, k_cnt, n_cnt;
  logic signed [IN_W:0]    x  [N];
  logic signed [OUT_W-1:0] yv [N];
  logic signed [AW-1:0]    acc;
`ifdef DCT_INV_EN
  logic                    inv_r;
`endif

  logic signed [IN_W:0]    x_in;
  logic [LOGN-1:0]         row, col;
  logic [2:0]              row8;
  logic signed [7:0]       coef;
  logic signed [AW-1:0]    prod, sum_now;
  logic signed [RW-1:0]    rounded, shifted;
  logic signed [OUT_W-1:0] y_new;

  assign state_dbg = state;

  // Forward samples are unsigned; inverse samples are signed coefficients.
  always_comb begin
    x_in = {1'b0, in_data};
`ifdef DCT_INV_EN
    if ((s_cnt == '0) ? inv_mode : inv_r) x_in = {in_data[IN_W-1], in_data};
`endif
  end

  always_comb begin
    row = k_cnt;
    col = n_cnt;
`ifdef DCT_INV_EN
    if (inv_r) begin
      row = n_cnt;
      col = k_cnt;
    end
`endif
    row8    = (N == 8) ? 3'(row) : (3'(row) << 1);
    coef    = C8[row8][3'(col)];
    prod    = AW'(coef) * AW'(x[n_cnt]);
    sum_now = ((n_cnt == '0) ? '0 : acc) + prod;
    rounded = RW'(sum_now) + RND;
    shifted = rounded >>> SHIFT;
    if (longint'(shifted) > SAT_MAX)      y_new = OUT_W'(SAT_MAX);
    else if (longint'(shifted) < SAT_MIN) y_new = OUT_W'(SAT_MIN);
    else                                  y_new = OUT_W'(shifted);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_LOAD;
      s_cnt     <= '0;
      k_cnt     <= '0;
      n_cnt     <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < N; i++) begin
        x[i]  <= '0;
        yv[i] <= '0;
      end
`ifdef DCT_INV_EN
      inv_r     <= 1'b0;
`endif
    end else begin
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            x[s_cnt] <= x_in;
`ifdef DCT_INV_EN
            if (s_cnt == '0) inv_r <= inv_mode;
`endif
            if (s_cnt == LAST) begin
              s_cnt    <= '0;
              k_cnt    <= '0;
              n_cnt    <= '0;
              in_ready <= 1'b0;
              state    <= S_CALC;
            end else begin
              s_cnt <= s_cnt + ONE;
            end
          end else begin
            // A gap inside a block throws the partial block away.
            s_cnt <= '0;
          end
        end
        S_CALC: begin
          acc   <= sum_now;
          n_cnt <= n_cnt + ONE;
          if (n_cnt == LAST) begin
            yv[k_cnt] <= y_new;
            k_cnt     <= k_cnt + ONE;
            if (k_cnt == LAST) begin
              state     <= S_OUT;
              out_valid <= 1'b1;
              out_data  <= yv[0];
              k_cnt     <= ONE;
            end
          end
        end
        S_OUT: begin
          // k_cnt wraps to zero once y[N-1] has been presented.
          if (k_cnt == '0) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            in_ready  <= 1'b1;
            state     <= S_LOAD;
          end else begin
            out_data <= yv[k_cnt];
            k_cnt    <= k_cnt + ONE;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_npt.sv
// Bench for dct_npt (N=4): randomized and directed blocks checked against a matrix-product model.
module tb_dct_npt;
  localparam int N     = 4;
  localparam int IN_W  = 8;
  localparam int OUT_W = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_ready, out_valid;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       state_dbg;
  logic             s6_in_valid = 1'b0;
  logic [IN_W-1:0]  s6_in_data = '0;
  logic             s6_in_ready, s6_out_valid;
  logic [OUT_W-1:0] s6_out_data;
  logic [1:0]       s6_state_dbg;
`ifdef DCT_INV_EN
  logic             inv_mode = 1'b0;
  logic             s6_inv_mode = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [OUT_W-1:0] exp_q[$];

  localparam int C4 [4][4] = '{'{64, 64, 64, 64}, '{83, 36, -36, -83},
                               '{64, -64, -64, 64}, '{36, -83, 83, -36}};

  dct_npt #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef DCT_INV_EN
    .inv_mode(inv_mode),
`endif
    .out_valid(out_valid), .out_data(out_data), .state_dbg(state_dbg));

  dct_npt #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(6)) dut_s6 (
    .clk(clk), .rst(rst), .in_valid(s6_in_valid), .in_ready(s6_in_ready), .in_data(s6_in_data),
`ifdef DCT_INV_EN
    .inv_mode(s6_inv_mode),
`endif
    .out_valid(s6_out_valid), .out_data(s6_out_data), .state_dbg(s6_state_dbg));

  always #5 clk = ~clk;

  // y = C*x (forward) or C^T*x (inverse), rounded, shifted, saturated.
  function automatic void model(input int xs[4], input bit inv, input int sh);
    int s, r;
    for (int k = 0; k < N; k++) begin
      s = 0;
      for (int n = 0; n < N; n++) s += (inv ? C4[n][k] : C4[k][n]) * xs[n];
      r = (sh > 0) ? ((s + (1 << (sh - 1))) >>> sh) : s;
      if (r > 511) r = 511;
      if (r < -512) r = -512;
      exp_q.push_back(OUT_W'(r));
    end
  endfunction

  task automatic drive_block(input int xs[4], input bit inv, input bit now);
    for (int i = 0; i < N; i++) begin
      if (!(now && i == 0)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = xs[i][IN_W-1:0];
`ifdef DCT_INV_EN
      inv_mode = (i == 0) ? inv : 1'($urandom);
`endif
    end
  endtask

  task automatic collect(input string name, input bit junk);
    int lat;
    bit seen;
    logic [OUT_W-1:0] e;
    lat = 0;
    seen = 1'b0;
    @(negedge clk);
    in_valid = junk;
    in_data  = IN_W'($urandom);
    for (int j = 1; j <= 100 && !seen; j++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        lat  = j;
      end else in_data = IN_W'($urandom);
    end
    in_valid = 1'b0;
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s timeout: out_valid never rose within 100 cycles, expected after %0d", name, N * N);
      repeat (N) if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    n_vec++;
    if (lat != N * N) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, N * N);
    end
    for (int i = 0; i < N; i++) begin
      if (i > 0) @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== e) begin
        n_err++;
        $display("FAIL %s y[%0d]: got valid=%b data=%0d, expected valid=1 data=%0d",
                 name, i, out_valid, $signed(out_data), $signed(e));
      end
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s tail: got valid=%b data=%0d ready=%b, expected 0/0/1",
               name, out_valid, out_data, in_ready);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 ||
        s6_in_ready !== 1'b1 || s6_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset: got ready=%b valid=%b data=%0d, expected 1/0/0", in_ready, out_valid, out_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    int xs[4];
    xs = '{100, 100, 100, 100};
    model(xs, 1'b0, 7);
    drive_block(xs, 1'b0, 1'b0);
    collect("dc", 1'b0);
    xs = '{255, 0, 0, 0};
    model(xs, 1'b0, 7);
    drive_block(xs, 1'b0, 1'b0);
    collect("impulse", 1'b0);
  endtask

  task automatic test_saturation;
    int xs[4];
    int pats[2][4];
    logic [OUT_W-1:0] e;
    bit seen;
    pats = '{'{255, 255, 255, 255}, '{0, 0, 255, 255}};
    for (int p = 0; p < 2; p++) begin
      xs = pats[p];
      model(xs, 1'b0, 6);
      for (int i = 0; i < N; i++) begin
        @(negedge clk);
        s6_in_valid = 1'b1;
        s6_in_data  = xs[i][IN_W-1:0];
      end
      @(negedge clk);
      s6_in_valid = 1'b0;
      seen = 1'b0;
      for (int j = 1; j <= 100 && !seen; j++) begin
        @(negedge clk);
        if (s6_out_valid === 1'b1) seen = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (i > 0) @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_vec++;
        if (s6_out_valid !== 1'b1 || s6_out_data !== e) begin
          n_err++;
          $display("FAIL sat%0d y[%0d]: got valid=%b data=%0d, expected valid=1 data=%0d",
                   p, i, s6_out_valid, $signed(s6_out_data), $signed(e));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_partial;
    int xs[4];
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'd77;
    end
    @(negedge clk);
    in_valid = 1'b0;
    xs = '{100, 100, 100, 100};
    model(xs, 1'b0, 7);
    drive_block(xs, 1'b0, 1'b0);
    collect("partial", 1'b0);
  endtask

  task automatic test_reset_mid;
    int xs[4];
    bit bad;
    xs = '{100, 100, 100, 100};
    drive_block(xs, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      n_err++;
      $display("FAIL rst_mid: got ready=%b valid=%b data=%0d, expected 1/0/0", in_ready, out_valid, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL rst_mid_quiet: got output or busy after abandoned block, expected idle");
    end
    xs = '{255, 0, 0, 0};
    model(xs, 1'b0, 7);
    drive_block(xs, 1'b0, 1'b0);
    collect("after_rst", 1'b0);
  endtask

  task automatic test_random;
    int xs[4];
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < N; i++) xs[i] = $urandom_range(0, 255);
      model(xs, 1'b0, 7);
      drive_block(xs, 1'b0, 1'b0);
      collect($sformatf("rand%0d", b), b[0]);
    end
  endtask

  task automatic test_back_to_back;
    int xs[4];
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < N; i++) xs[i] = (b == 2) ? 255 : $urandom_range(0, 255);
      model(xs, 1'b0, 7);
      drive_block(xs, 1'b0, b > 0);
      collect($sformatf("b2b%0d", b), 1'b0);
    end
  endtask

`ifdef DCT_INV_EN
  task automatic test_inverse;
    int xs[4], sv[4];
    xs = '{100, 0, 0, 0};
    model(xs, 1'b1, 7);
    drive_block(xs, 1'b1, 1'b0);
    collect("inv_dc", 1'b0);
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < N; i++) begin
        xs[i] = $urandom_range(0, 255);
        sv[i] = (xs[i] >= 128) ? xs[i] - 256 : xs[i];
      end
      model(sv, 1'b1, 7);
      drive_block(xs, 1'b1, 1'b0);
      collect($sformatf("inv%0d", b), 1'b0);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_directed;
    test_saturation;
    test_partial;
    test_reset_mid;
    test_random;
    test_back_to_back;
`ifdef DCT_INV_EN
    test_inverse;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
endmodule
